life_gen_controller: RTL and testbench
======================================

Name: life_gen_controller

Overview:
- Sequences one Game-of-Life generation update over the sprite-cell matrix, a 20 x 15 grid of 32 x 32-pixel sprites.
- Reads the current (front) buffer row by row through a synchronous row-read port.
- Computes each next row with the B3/S23 rule and writes it into the back buffer.
- Pulses a swap at the end of the generation so the display-side matrix shows the new generation.
- Sits between the frame-timing logic (frame-start pulse) and the double-buffered matrix storage.

Parameters:
- COLS, 20, cells per row (row word width).
- ROWS, 15, number of rows.
- ROW_W, 4, row address width; must satisfy 2^ROW_W >= ROWS.
- PERIOD, 30, frame-start pulses per automatic generation; must be >= 1.
- WRAP, 1, 1 = toroidal edges; 0 = out-of-grid neighbours read as dead.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_frame_start  in  1  one-cycle pulse at start of vertical blank.
- i_enable  in  1  1 = free-run, one generation every PERIOD frames.
- i_step  in  1  one-cycle pulse; requests a single generation regardless of i_enable.
- o_rd_row  out  ROW_W  front-buffer row address.
- i_rd_data  in  COLS  front-buffer row data; valid one cycle after o_rd_row is presented.
- o_wr_en  out  1  back-buffer write strobe.
- o_wr_row  out  ROW_W  back-buffer row address.
- o_wr_data  out  COLS  next-generation row.
- o_swap  out  1  one-cycle pulse; buffer roles exchange.
- o_busy  out  1  high from generation start through the swap cycle.
- o_generation  out  16  completed-generation count; wraps at 65535 -> 0.

Behaviour:
- Interface: one clock, i_clk; reset i_reset is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; frame counter 0; pending flag 0; row index 0.
- Frame counter: increments on each i_frame_start while i_enable=1.
  - A pulse arriving at count PERIOD-1 clears the counter and sets pending.
  - While i_enable=0 the counter holds at its current value; it is not cleared.
- i_step pulse sets pending.
- Pending is a single flag:
  - Further requests while set, or while a generation is busy, are absorbed; at most one queued generation.
  - Pending clears when IDLE accepts it.
  - Simultaneous step and frame-period expiry produce one pending.
- FSM states: IDLE, RD_UP, RD_MID, RD_DN, WRITE, SWAP.
  - IDLE: if pending, then r<=0, clear pending, set busy, go to RD_UP.
  - RD_UP: o_rd_row = r-1 (wraps to ROWS-1 when r=0).
  - RD_MID: o_rd_row = r; capture i_rd_data as up.
  - RD_DN: o_rd_row = r+1 (wraps to 0 when r=ROWS-1); capture mid.
  - WRITE: capture dn combinationally into the compute path; o_wr_en=1, o_wr_row=r, o_wr_data=next(up,mid,dn). If r=ROWS-1 go to SWAP, else r<=r+1 and go to RD_UP.
  - SWAP: o_swap=1, o_generation+=1, go to IDLE; busy drops on the cycle after SWAP.
- WRAP=0: up row is forced to 0 when r=0; dn row is forced to 0 when r=ROWS-1. The read is still issued, but its data is ignored.
- Latency:
  - 4 cycles per row; ROWS*4+1 = 61 cycles from leaving IDLE to the end of SWAP.
  - Pending to first o_rd_row: 1 cycle.
- o_rd_row holds its last value in IDLE. o_wr_en is 0 outside WRITE. o_wr_data is don't-care when o_wr_en=0.
- Per-cell rule for column c:
  - n = sum of the 8 neighbours from up/mid/dn at c-1, c, c+1, excluding mid[c].
  - Column index wraps modulo COLS when WRAP=1; out-of-range columns read 0 when WRAP=0.
  - n is 4 bits, range 0..8.
  - next[c] = (n==3) | (mid[c] & n==2).
- Reset mid-generation: abort immediately; no further write, no swap, o_generation reset to 0.
- i_enable falling mid-generation: the current generation completes.

Test Plan:
- Blinker: PERIOD=1, i_enable=1; front rows 6,7,8 have only bit 10 set.
  - One frame pulse -> writes rows 0..14 in order.
  - Row 7 = bit 9|10|11; rows 6 and 8 = 0.
  - Single o_swap 61 cycles after start; o_generation=1.
- Read ordering: start a generation -> o_rd_row sequence 14,0,1 for r=0, then 0,1,2; last row reads 13,14,0.
- Edge wrap: glider at rows 0-2 / cols 18-19,0 with WRAP=1 -> crosses boundaries correctly.
  - Same stimulus with WRAP=0 -> row 14 and col 0 neighbours are dead; a single cell at (0,0) with cells (14,19),(14,0) gives dead result.
- Rate control: PERIOD=4, i_enable=1 -> generations start only after the 4th, 8th, ... frame pulse.
  - i_enable=0 -> no starts; i_step pulse -> exactly one generation.
  - Step plus frame pulses during busy -> exactly one follow-on generation.
- Still life: 2x2 block at rows 3-4 / cols 5-6 -> written rows identical to front across 3 generations; o_generation=3.
- Reset mid-op: assert i_reset during WRITE of row 7 -> next cycle o_wr_en=0, o_busy=0, o_generation=0; no o_swap ever pulses for that generation.

Source files
------------

// File: rtl/life_gen_controller.sv
// Game-of-Life generation sequencer: reads the front buffer a row at a time,
// applies B3/S23 per row and writes the back buffer, then pulses a buffer swap.
module life_gen_controller #(
   parameter int COLS   = 20,
   parameter int ROWS   = 15,
   parameter int ROW_W  = 4,
   parameter int PERIOD = 30,
   parameter int WRAP   = 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_frame_start,
   input  logic               i_enable,
   input  logic               i_step,
   output logic [ROW_W-1:0]   o_rd_row,
   input  logic [COLS-1:0]    i_rd_data,
   output logic               o_wr_en,
   output logic [ROW_W-1:0]   o_wr_row,
   output logic [COLS-1:0]    o_wr_data,
   output logic               o_swap,
   output logic               o_busy,
   output logic [15:0]        o_generation
);

   localparam int               CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE, RD_UP, RD_MID, RD_DN, WRITE, SWAP
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  frame_cnt;
   logic              pending;
   logic              period_hit;
   logic              accept;
   logic [ROW_W-1:0]  r, r_n;
   logic [ROW_W-1:0]  rd_row_n;
   logic [COLS-1:0]   up_q, mid_q;
   logic [15:0]       gen_q;
   logic [COLS-1:0]   up_eff, dn_eff;
   logic [COLS+1:0]   up_x, mid_x, dn_x;
   logic [COLS-1:0]   next_row;

   assign period_hit = i_frame_start & i_enable & (frame_cnt == CNT_LAST);
   assign accept     = (state == IDLE) & pending;

   // A request arriving while pending is already set (including the accept
   // cycle) merges into the single queued generation.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         frame_cnt <= '0;
         pending   <= 1'b0;
      end else begin
         if (i_frame_start & i_enable)
            frame_cnt <= period_hit ? '0 : frame_cnt + 1'b1;
         if (accept)
            pending <= 1'b0;
         else if (i_step | period_hit)
            pending <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         r        <= '0;
         o_rd_row <= '0;
         up_q     <= '0;
         mid_q    <= '0;
         gen_q    <= '0;
      end else begin
         state    <= state_n;
         r        <= r_n;
         o_rd_row <= rd_row_n;
         if (state == RD_MID) up_q  <= i_rd_data;
         if (state == RD_DN)  mid_q <= i_rd_data;
         if (state == SWAP)   gen_q <= gen_q + 1'b1;
      end
   end

   // The read address is registered and set on entry to each read state, so
   // it is stable for the whole state and holds its last value in IDLE.
   always_comb begin
      state_n   = state;
      r_n       = r;
      rd_row_n  = o_rd_row;
      o_wr_en   = 1'b0;
      o_wr_row  = r;
      o_wr_data = next_row;
      o_swap    = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               r_n      = '0;
               rd_row_n = ROW_LAST;
               state_n  = RD_UP;
            end
         end
         RD_UP: begin
            rd_row_n = r;
            state_n  = RD_MID;
         end
         RD_MID: begin
            rd_row_n = (r == ROW_LAST) ? '0 : r + 1'b1;
            state_n  = RD_DN;
         end
         RD_DN: state_n = WRITE;
         WRITE: begin
            o_wr_en = 1'b1;
            if (r == ROW_LAST) begin
               state_n = SWAP;
            end else begin
               r_n      = r + 1'b1;
               rd_row_n = r;
               state_n  = RD_UP;
            end
         end
         SWAP: begin
            o_swap  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign o_busy       = (state != IDLE);
   assign o_generation = gen_q;

   // Without wrap, the rows above the top and below the bottom read as dead
   // even though the wrapped read was still issued.
   assign up_eff = ((WRAP == 0) && (r == '0))       ? '0 : up_q;
   assign dn_eff = ((WRAP == 0) && (r == ROW_LAST)) ? '0 : i_rd_data;

   // Extended rows: bit 0 is column -1, bit COLS+1 is column COLS.
   assign up_x  = (WRAP != 0) ? {up_eff[0], up_eff, up_eff[COLS-1]} : {1'b0, up_eff, 1'b0};
   assign mid_x = (WRAP != 0) ? {mid_q[0],  mid_q,  mid_q[COLS-1]}  : {1'b0, mid_q,  1'b0};
   assign dn_x  = (WRAP != 0) ? {dn_eff[0], dn_eff, dn_eff[COLS-1]} : {1'b0, dn_eff, 1'b0};

   for (genvar c = 0; c < COLS; c++) begin : g_cell
      logic [3:0] n;
      assign n = {3'b0, up_x[c]}  + {3'b0, up_x[c+1]} + {3'b0, up_x[c+2]}
               + {3'b0, mid_x[c]}                     + {3'b0, mid_x[c+2]}
               + {3'b0, dn_x[c]}  + {3'b0, dn_x[c+1]} + {3'b0, dn_x[c+2]};
      assign next_row[c] = (n == 4'd3) | (mid_x[c+1] & (n == 4'd2));
   end

endmodule

// File: tb/tb_life_gen_controller.sv
// Directed bench: a wrapping and a non-wrapping controller share one modelled
// double-buffered matrix; row vectors come from a table, corners are sequences.
module tb_life_gen_controller;

   localparam int COLS   = 20;
   localparam int ROWS   = 15;
   localparam int ROW_W  = 4;
   localparam int PERIOD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_reset, i_frame_start, i_enable, i_step;
   logic [COLS-1:0]   i_rd_data;
   logic [ROW_W-1:0]  o_rd_row, o_wr_row, o_rd_row_n, o_wr_row_n;
   logic [COLS-1:0]   o_wr_data, o_wr_data_n;
   logic              o_wr_en, o_swap, o_busy, o_wr_en_n, o_swap_n, o_busy_n;
   logic [15:0]       o_generation, o_generation_n;

   life_gen_controller #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .PERIOD(PERIOD), .WRAP(1)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_frame_start(i_frame_start), .i_enable(i_enable),
      .i_step(i_step), .o_rd_row(o_rd_row), .i_rd_data(i_rd_data), .o_wr_en(o_wr_en),
      .o_wr_row(o_wr_row), .o_wr_data(o_wr_data), .o_swap(o_swap), .o_busy(o_busy),
      .o_generation(o_generation));

   life_gen_controller #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .PERIOD(PERIOD), .WRAP(0)) dut_nw (
      .i_clk(clk), .i_reset(i_reset), .i_frame_start(i_frame_start), .i_enable(i_enable),
      .i_step(i_step), .o_rd_row(o_rd_row_n), .i_rd_data(i_rd_data), .o_wr_en(o_wr_en_n),
      .o_wr_row(o_wr_row_n), .o_wr_data(o_wr_data_n), .o_swap(o_swap_n), .o_busy(o_busy_n),
      .o_generation(o_generation_n));

   logic [COLS-1:0]  front[ROWS];
   logic [COLS-1:0]  back[ROWS];
   logic [COLS-1:0]  back_n[ROWS];
   logic [ROW_W-1:0] exp_q[$];
   int               rd_log[$];
   int               wr_log[$];
   int               checks = 0;
   int               failures = 0;
   int               swap_cnt = 0;
   int               swap_idx = -1;

   // Synchronous front-buffer read port: data valid one cycle after address.
   always @(posedge clk) i_rd_data <= front[o_rd_row];

   typedef struct {
      logic [COLS-1:0] up;
      logic [COLS-1:0] mid;
      logic [COLS-1:0] dn;
      logic [COLS-1:0] exp_wrap;
      logic [COLS-1:0] exp_nowrap;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (o_busy) rd_log.push_back(int'(o_rd_row));
      if (o_wr_en) begin
         back[o_wr_row] = o_wr_data;
         wr_log.push_back(int'(o_wr_row));
      end
      if (o_wr_en_n) back_n[o_wr_row_n] = o_wr_data_n;
      if (o_swap) begin
         swap_cnt++;
         swap_idx = rd_log.size() - 1;
         front = back;
      end
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_frame();
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      idle_ticks(2);
   endtask

   task automatic wait_gen_done(input string name);
      int t;
      t = 0;
      while (!o_busy && t < 20) begin tick(); t++; end
      check({name, " started"}, 32'(o_busy), 32'd1);
      t = 0;
      while (o_busy && t < 200) begin tick(); t++; end
      check({name, " finished"}, 32'(o_busy), 32'd0);
   endtask

   task automatic run_step(input string name);
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      wait_gen_done(name);
   endtask

   task automatic clear_img();
      for (int i = 0; i < ROWS; i++) begin
         front[i]  = '0;
         back[i]   = '0;
         back_n[i] = '0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int swaps0;
      int t;
      logic [COLS-1:0] rest;

      vecs[0] = '{up: 20'h0,     mid: 20'h00E00, dn: 20'h0,     exp_wrap: 20'h00400, exp_nowrap: 20'h00400};
      vecs[1] = '{up: 20'h00400, mid: 20'h00400, dn: 20'h00400, exp_wrap: 20'h00E00, exp_nowrap: 20'h00E00};
      vecs[2] = '{up: 20'h0,     mid: 20'h0,     dn: 20'h0,     exp_wrap: 20'h0,     exp_nowrap: 20'h0};
      vecs[3] = '{up: 20'h00E00, mid: 20'h00E00, dn: 20'h00E00, exp_wrap: 20'h01100, exp_nowrap: 20'h01100};
      vecs[4] = '{up: 20'h0,     mid: 20'h80003, dn: 20'h0,     exp_wrap: 20'h00001, exp_nowrap: 20'h0};
      vecs[5] = '{up: 20'h00014, mid: 20'h0,     dn: 20'h00008, exp_wrap: 20'h00008, exp_nowrap: 20'h00008};
      vecs[6] = '{up: 20'h08000, mid: 20'h18000, dn: 20'h0,     exp_wrap: 20'h18000, exp_nowrap: 20'h18000};
      vecs[7] = '{up: 20'h80000, mid: 20'h80000, dn: 20'h80000, exp_wrap: 20'hC0001, exp_nowrap: 20'hC0000};

      clear_img();
      i_reset = 1'b1; i_frame_start = 1'b0; i_enable = 1'b0; i_step = 1'b0;
      @(negedge clk);
      idle_ticks(3);
      check("reset rd_row",     32'(o_rd_row), 32'd0);
      check("reset wr_en",      32'(o_wr_en), 32'd0);
      check("reset wr_row",     32'(o_wr_row), 32'd0);
      check("reset wr_data",    32'(o_wr_data), 32'd0);
      check("reset swap",       32'(o_swap), 32'd0);
      check("reset busy",       32'(o_busy), 32'd0);
      check("reset generation", 32'(o_generation), 32'd0);
      i_reset = 1'b0;
      tick();

      // Blinker, started by the 4th frame pulse.
      front[6] = 20'h00400; front[7] = 20'h00400; front[8] = 20'h00400;
      rd_log.delete(); wr_log.delete();
      i_enable = 1'b1;
      for (int i = 0; i < 3; i++) pulse_frame();
      idle_ticks(4);
      check("no start before 4th pulse", 32'(rd_log.size()), 32'd0);
      swaps0 = swap_cnt;
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      wait_gen_done("blinker");
      check("blinker busy cycles", 32'(rd_log.size()), 32'd61);
      check("blinker swap cycle", 32'(swap_idx), 32'd60);
      check("blinker swap count", 32'(swap_cnt - swaps0), 32'd1);
      check("blinker generation", 32'(o_generation), 32'd1);
      check("blinker row6", 32'(front[6]), 32'h0);
      check("blinker row7", 32'(front[7]), 32'h00E00);
      check("blinker row8", 32'(front[8]), 32'h0);
      check("blinker nowrap row7", 32'(back_n[7]), 32'h00E00);
      for (int i = 0; i < ROWS; i++) exp_q.push_back(ROW_W'(i));
      check("write count", 32'(wr_log.size()), 32'd15);
      foreach (wr_log[i]) check("write order", 32'(wr_log[i]), 32'(exp_q.pop_front()));
      check("rd r0 up",   32'(rd_log[0]),  32'd14);
      check("rd r0 mid",  32'(rd_log[1]),  32'd0);
      check("rd r0 dn",   32'(rd_log[2]),  32'd1);
      check("rd r1 up",   32'(rd_log[4]),  32'd0);
      check("rd r1 mid",  32'(rd_log[5]),  32'd1);
      check("rd r1 dn",   32'(rd_log[6]),  32'd2);
      check("rd r14 up",  32'(rd_log[56]), 32'd13);
      check("rd r14 mid", 32'(rd_log[57]), 32'd14);
      check("rd r14 dn",  32'(rd_log[58]), 32'd0);

      // Disabled: frame pulses start nothing; a step runs exactly one.
      i_enable = 1'b0;
      rd_log.delete();
      for (int i = 0; i < 8; i++) pulse_frame();
      check("disabled no start", 32'(rd_log.size()), 32'd0);
      swaps0 = swap_cnt;
      run_step("step");
      idle_ticks(20);
      check("step swap count", 32'(swap_cnt - swaps0), 32'd1);
      check("step generation", 32'(o_generation), 32'd2);
      check("step row6", 32'(front[6]), 32'h00400);
      check("step row7", 32'(front[7]), 32'h00400);

      // Step plus a full frame period while busy: one follow-on only.
      rd_log.delete();
      swaps0 = swap_cnt;
      i_step = 1'b1; tick(); i_step = 1'b0;
      t = 0;
      while (!o_busy && t < 20) begin tick(); t++; end
      i_step = 1'b1; tick(); i_step = 1'b0;
      i_enable = 1'b1;
      for (int i = 0; i < 4; i++) pulse_frame();
      i_enable = 1'b0;
      t = 0;
      while (swap_cnt < swaps0 + 2 && t < 300) begin tick(); t++; end
      idle_ticks(80);
      check("follow-on swap count", 32'(swap_cnt - swaps0), 32'd2);
      check("follow-on busy cycles", 32'(rd_log.size()), 32'd122);
      check("follow-on generation", 32'(o_generation), 32'd4);

      // Row-rule table: rows 4/5/6 loaded, row 5 checked on both controllers.
      foreach (vecs[i]) begin
         clear_img();
         front[4] = vecs[i].up; front[5] = vecs[i].mid; front[6] = vecs[i].dn;
         run_step($sformatf("vec%0d", i));
         check($sformatf("vec%0d wrap", i),   32'(back[5]),   32'(vecs[i].exp_wrap));
         check($sformatf("vec%0d nowrap", i), 32'(back_n[5]), 32'(vecs[i].exp_nowrap));
      end
      check("table generation", 32'(o_generation), 32'd12);

      // Corner cells across the top/bottom and left/right edges.
      clear_img();
      front[0] = 20'h00001; front[14] = 20'h80001;
      run_step("edge");
      for (int i = 0; i < ROWS; i++) begin
         check($sformatf("edge wrap row%0d", i), 32'(back[i]),
               (i == 0 || i == 14) ? 32'h80001 : 32'h0);
         check($sformatf("edge nowrap row%0d", i), 32'(back_n[i]), 32'h0);
      end

      // Block still life over three generations.
      clear_img();
      front[3] = 20'h00060; front[4] = 20'h00060;
      for (int g = 0; g < 3; g++) begin
         run_step($sformatf("block%0d", g));
         rest = '0;
         for (int i = 0; i < ROWS; i++) if (i != 3 && i != 4) rest |= front[i];
         check($sformatf("block%0d row3", g), 32'(front[3]), 32'h00060);
         check($sformatf("block%0d row4", g), 32'(front[4]), 32'h00060);
         check($sformatf("block%0d others", g), 32'(rest), 32'h0);
      end
      check("block generation", 32'(o_generation), 32'd16);

      // Reset while row 7 is being written.
      clear_img();
      front[7] = 20'h00E00;
      swaps0 = swap_cnt;
      i_step = 1'b1; tick(); i_step = 1'b0;
      t = 0;
      while (!(o_wr_en && o_wr_row == 4'd7) && t < 100) begin tick(); t++; end
      check("reached row7 write", 32'(o_wr_en && o_wr_row == 4'd7), 32'd1);
      i_reset = 1'b1;
      tick();
      check("abort wr_en", 32'(o_wr_en), 32'd0);
      check("abort busy", 32'(o_busy), 32'd0);
      check("abort generation", 32'(o_generation), 32'd0);
      check("abort nowrap generation", 32'(o_generation_n), 32'd0);
      i_reset = 1'b0;
      idle_ticks(100);
      check("abort no swap", 32'(swap_cnt - swaps0), 32'd0);
      check("abort still idle", 32'(o_busy), 32'd0);
      check("abort generation held", 32'(o_generation), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
